// File: rtl/branch_resolve_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// branch_resolve_ctrl_pkg
// Shared definitions for the decode-stage branch resolve controller:
//   - CMP_* comparator mode codes (CMP_NONE is the idle/default code)
//   - FWD_* forwarding source select codes
//   - brState_e FSM state codes (BR_IDLE / BR_STALL)
// No ports (package).
// -----------------------------------------------------------------------------
package branch_resolve_ctrl_pkg;

  // Comparator mode codes shared with decode and the comparator
  localparam logic [3:0] CMP_NONE = 4'd0;
  localparam logic [3:0] CMP_BEQ  = 4'd1;
  localparam logic [3:0] CMP_BNE  = 4'd2;
  localparam logic [3:0] CMP_BLEZ = 4'd3;
  localparam logic [3:0] CMP_BGTZ = 4'd4;
  localparam logic [3:0] CMP_BLTZ = 4'd5;
  localparam logic [3:0] CMP_BGEZ = 4'd6;

  // Forwarding source selects for the comparator operand muxes
  localparam logic [1:0] FWD_RF  = 2'd0;
  localparam logic [1:0] FWD_EX  = 2'd1;
  localparam logic [1:0] FWD_MEM = 2'd2;
  localparam logic [1:0] FWD_WB  = 2'd3;

  // Branch controller FSM states
  typedef enum logic {
    BR_IDLE  = 1'b0,
    BR_STALL = 1'b1
  } brState_e;

endpackage

// File: rtl/branch_resolve_ctrl_if.sv
// -----------------------------------------------------------------------------
// branch_resolve_ctrl_if
// Bundle between decode and the branch resolve controller.
//   Decode side (master) drives: id_valid, id_is_branch, id_use_rt, id_rs,
//     id_rt, id_cmp_mode, id_wr_en, id_wr_reg, id_tnew, cmp_result.
//   Controller side (slave) drives: stall, cmp_mode, fwd_rs_sel, fwd_rt_sel,
//     br_taken.
// -----------------------------------------------------------------------------
interface branch_resolve_ctrl_if #(
  parameter int TNEW_W = 2
);
  logic              id_valid;
  logic              id_is_branch;
  logic              id_use_rt;
  logic [4:0]        id_rs;
  logic [4:0]        id_rt;
  logic [3:0]        id_cmp_mode;
  logic              id_wr_en;
  logic [4:0]        id_wr_reg;
  logic [TNEW_W-1:0] id_tnew;
  logic              cmp_result;
  logic              stall;
  logic [3:0]        cmp_mode;
  logic [1:0]        fwd_rs_sel;
  logic [1:0]        fwd_rt_sel;
  logic              br_taken;

  modport master (
    output id_valid, id_is_branch, id_use_rt, id_rs, id_rt, id_cmp_mode,
           id_wr_en, id_wr_reg, id_tnew, cmp_result,
    input  stall, cmp_mode, fwd_rs_sel, fwd_rt_sel, br_taken
  );

  modport slave (
    input  id_valid, id_is_branch, id_use_rt, id_rs, id_rt, id_cmp_mode,
           id_wr_en, id_wr_reg, id_tnew, cmp_result,
    output stall, cmp_mode, fwd_rs_sel, fwd_rt_sel, br_taken
  );
endinterface

// File: rtl/branch_resolve_ctrl_scoreboard.sv
// -----------------------------------------------------------------------------
// branch_resolve_ctrl_scoreboard
// Three-entry in-flight writer tracker (E, M, W) with two lookup ports.
// Ports:
//   clk, reset        clock / synchronous active-high reset
//   load_en_i         load a valid writer into E (otherwise E gets a bubble)
//   load_reg_i        destination register of the new writer
//   load_tnew_i       cycles from EX entry until the writer's result forwards
//   rs_i, rt_i        registers looked up by the branch in ID
//   use_rt_i          rt participates in the hazard check
//   hazard_o          some needed operand is not yet forwardable
//   fwd_rs_sel_o      forwarding source for rs (FWD_* code)
//   fwd_rt_sel_o      forwarding source for rt (FWD_* code)
// -----------------------------------------------------------------------------
module branch_resolve_ctrl_scoreboard
  import branch_resolve_ctrl_pkg::*;
#(
  parameter int TNEW_W = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load_en_i,
  input  logic [4:0]        load_reg_i,
  input  logic [TNEW_W-1:0] load_tnew_i,
  input  logic [4:0]        rs_i,
  input  logic [4:0]        rt_i,
  input  logic              use_rt_i,
  output logic              hazard_o,
  output logic [1:0]        fwd_rs_sel_o,
  output logic [1:0]        fwd_rt_sel_o
);

  localparam logic [TNEW_W-1:0] TNEW_ONE = 1;

  // Index 0 = E (youngest), 1 = M, 2 = W (oldest)
  logic [2:0]             entryValid_q, entryValid_d;
  logic [2:0][4:0]        entryReg_q,   entryReg_d;
  logic [2:0][TNEW_W-1:0] entryTnew_q,  entryTnew_d;

  logic [2:0] rsLookup;
  logic [2:0] rtLookup;

  // Youngest match decides the forward source; a younger match that is still
  // in flight masks older ready copies, and any in-flight match is a hazard.
  function automatic logic [2:0] lookupReg(
    input logic [4:0]             r,
    input logic [2:0]             v,
    input logic [2:0][4:0]        regs,
    input logic [2:0][TNEW_W-1:0] t
  );
    logic       hz;
    logic       found;
    logic [1:0] sel;
    hz    = 1'b0;
    found = 1'b0;
    sel   = FWD_RF;
    for (int i = 0; i < 3; i++) begin
      if (v[i] && (regs[i] == r) && (r != 5'd0)) begin
        if (t[i] != '0) begin
          hz = 1'b1;
        end else if (!found) begin
          sel = 2'(i + 1);
        end
        found = 1'b1;
      end
    end
    return {hz, sel};
  endfunction

  // Next pipeline contents: new writer (or bubble) enters E, older entries
  // shift toward W and count their remaining latency down to zero.
  always_comb begin
    entryValid_d   = '0;
    entryReg_d     = '0;
    entryTnew_d    = '0;
    entryValid_d[0] = load_en_i;
    entryReg_d[0]   = load_reg_i;
    entryTnew_d[0]  = load_tnew_i;
    for (int i = 1; i < 3; i++) begin
      entryValid_d[i] = entryValid_q[i-1];
      entryReg_d[i]   = entryReg_q[i-1];
      entryTnew_d[i]  = (entryTnew_q[i-1] == '0) ? '0 : (entryTnew_q[i-1] - TNEW_ONE);
    end
  end

  // Entry registers; reset empties the tracker
  always_ff @(posedge clk) begin
    if (reset) begin
      entryValid_q <= '0;
      entryReg_q   <= '0;
      entryTnew_q  <= '0;
    end else begin
      entryValid_q <= entryValid_d;
      entryReg_q   <= entryReg_d;
      entryTnew_q  <= entryTnew_d;
    end
  end

  // Both lookup ports see the same entries; rt only gates the hazard when used
  always_comb begin
    rsLookup     = lookupReg(rs_i, entryValid_q, entryReg_q, entryTnew_q);
    rtLookup     = lookupReg(rt_i, entryValid_q, entryReg_q, entryTnew_q);
    hazard_o     = rsLookup[2] | (use_rt_i & rtLookup[2]);
    fwd_rs_sel_o = rsLookup[1:0];
    fwd_rt_sel_o = rtLookup[1:0];
  end

endmodule

// File: rtl/branch_resolve_ctrl.sv
// -----------------------------------------------------------------------------
// branch_resolve_ctrl
// Decode-stage controller sequencing the branch comparator: tracks in-flight
// writers, stalls a branch until its operands are forwardable, selects the
// forwarding sources and turns the comparator result into a PC redirect.
// Ports:
//   clk, reset           clock / synchronous active-high reset
//   bus (slave)          decode inputs, cmp_result; stall, cmp_mode,
//                        fwd_rs_sel, fwd_rt_sel, br_taken outputs
//   perf_branches_o      resolved branches      (BRANCH_PERF_EN only)
//   perf_taken_o         taken branches         (BRANCH_PERF_EN only)
//   perf_stall_cyc_o     cycles spent in STALL  (BRANCH_PERF_EN only)
// Optional feature macro: BRANCH_PERF_EN (performance counters).
// -----------------------------------------------------------------------------
module branch_resolve_ctrl
  import branch_resolve_ctrl_pkg::*;
#(
  parameter int TNEW_W = 2,
  parameter int PERF_W = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  branch_resolve_ctrl_if.slave  bus
`ifdef BRANCH_PERF_EN
  ,
  output logic [PERF_W-1:0]     perf_branches_o,
  output logic [PERF_W-1:0]     perf_taken_o,
  output logic [PERF_W-1:0]     perf_stall_cyc_o
`endif
);

  brState_e   state_q, state_d;
  logic [1:0] stallCnt_q, stallCnt_d;
  logic       hazard;
  logic       stallSig;
  logic       resolve;
  logic       loadEn;
  logic       isBranch;

  assign isBranch = bus.id_valid & bus.id_is_branch;

  // Writes to $0 never enter the tracker, and a stalled ID slot issues a bubble
  assign loadEn = ~stallSig & bus.id_valid & bus.id_wr_en & (bus.id_wr_reg != 5'd0);

  branch_resolve_ctrl_scoreboard #(
    .TNEW_W (TNEW_W)
  ) u_scoreboard (
    .clk          (clk),
    .reset        (reset),
    .load_en_i    (loadEn),
    .load_reg_i   (bus.id_wr_reg),
    .load_tnew_i  (bus.id_tnew),
    .rs_i         (bus.id_rs),
    .rt_i         (bus.id_rt),
    .use_rt_i     (bus.id_use_rt),
    .hazard_o     (hazard),
    .fwd_rs_sel_o (bus.fwd_rs_sel),
    .fwd_rt_sel_o (bus.fwd_rt_sel)
  );

  // Branch operands are needed in ID itself, so any in-flight producer holds
  // the branch; the cycle the hazard clears is also the resolve cycle.
  always_comb begin
    stallSig   = 1'b0;
    resolve    = 1'b0;
    state_d    = state_q;
    stallCnt_d = stallCnt_q;
    case (state_q)
      BR_IDLE: begin
        if (isBranch) begin
          if (hazard) begin
            stallSig   = 1'b1;
            state_d    = BR_STALL;
            stallCnt_d = 2'd0;
          end else begin
            resolve = 1'b1;
          end
        end
      end
      BR_STALL: begin
        if (hazard) begin
          stallSig   = 1'b1;
          stallCnt_d = stallCnt_q + 2'd1;
        end else begin
          resolve    = 1'b1;
          state_d    = BR_IDLE;
          stallCnt_d = 2'd0;
        end
      end
      default: begin
        state_d    = BR_IDLE;
        stallCnt_d = 2'd0;
      end
    endcase
  end

  assign bus.stall    = stallSig;
  assign bus.cmp_mode = resolve ? bus.id_cmp_mode : CMP_NONE;
  assign bus.br_taken = resolve & bus.cmp_result;

  // FSM state and stall-length counter; reset abandons any pending branch
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= BR_IDLE;
      stallCnt_q <= 2'd0;
    end else begin
      state_q    <= state_d;
      stallCnt_q <= stallCnt_d;
    end
  end

`ifndef SYNTHESIS
  // Longest producer latency drains within three stall cycles
  always_ff @(posedge clk) begin
    if (!reset && (state_q == BR_STALL)) begin
      assert (!((stallCnt_q == 2'd3) && hazard));
    end
  end
`endif

`ifdef BRANCH_PERF_EN
  // Free-running event counters that simply wrap on overflow
  always_ff @(posedge clk) begin
    if (reset) begin
      perf_branches_o  <= '0;
      perf_taken_o     <= '0;
      perf_stall_cyc_o <= '0;
    end else begin
      if (resolve) begin
        perf_branches_o <= perf_branches_o + 1'b1;
      end
      if (bus.br_taken) begin
        perf_taken_o <= perf_taken_o + 1'b1;
      end
      if (state_q == BR_STALL) begin
        perf_stall_cyc_o <= perf_stall_cyc_o + 1'b1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_branch_resolve_ctrl.sv
// -----------------------------------------------------------------------------
// tb_branch_resolve_ctrl
// Self-checking bench for branch_resolve_ctrl. Each cycle's stimulus pushes
// the expected outputs onto a queue; they are popped and compared mid-cycle.
// Honours BRANCH_PERF_EN for the optional counter ports.
// -----------------------------------------------------------------------------
module tb_branch_resolve_ctrl;
  import branch_resolve_ctrl_pkg::*;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  branch_resolve_ctrl_if #(.TNEW_W(2)) bus();

`ifdef BRANCH_PERF_EN
  logic [31:0] perfBranches;
  logic [31:0] perfTaken;
  logic [31:0] perfStallCyc;
`endif

  branch_resolve_ctrl #(
    .TNEW_W (2),
    .PERF_W (32)
  ) dut (
    .clk              (clk),
    .reset            (reset),
    .bus              (bus)
`ifdef BRANCH_PERF_EN
    ,
    .perf_branches_o  (perfBranches),
    .perf_taken_o     (perfTaken),
    .perf_stall_cyc_o (perfStallCyc)
`endif
  );

  typedef struct {
    string      tag;
    logic       stall;
    logic [3:0] mode;
    logic [1:0] rsSel;
    logic [1:0] rtSel;
    logic       taken;
  } expect_t;

  expect_t expectQ[$];
  int checkCount = 0;
  int failCount  = 0;

  // Single comparison point: counts and reports mismatches
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
    end
  endtask

  // Drive one ID-stage slot and queue the outputs it should produce
  task automatic applyStimulus(
    input string tag, input logic valid, input logic isBr, input logic useRt,
    input logic [4:0] rs, input logic [4:0] rt, input logic [3:0] mode,
    input logic wrEn, input logic [4:0] wrReg, input logic [1:0] tnew,
    input logic cmpRes, input logic expStall, input logic [3:0] expMode,
    input logic [1:0] expRs, input logic [1:0] expRt, input logic expTaken);
    expect_t e;
    bus.id_valid     = valid;
    bus.id_is_branch = isBr;
    bus.id_use_rt    = useRt;
    bus.id_rs        = rs;
    bus.id_rt        = rt;
    bus.id_cmp_mode  = mode;
    bus.id_wr_en     = wrEn;
    bus.id_wr_reg    = wrReg;
    bus.id_tnew      = tnew;
    bus.cmp_result   = cmpRes;
    e.tag   = tag;
    e.stall = expStall;
    e.mode  = expMode;
    e.rsSel = expRs;
    e.rtSel = expRt;
    e.taken = expTaken;
    expectQ.push_back(e);
  endtask

  // Pop the oldest expectation and compare against the live outputs
  task automatic compareOutputs();
    expect_t e;
    checkOutput("queue_size", expectQ.size(), 1);
    if (expectQ.size() > 0) begin
      e = expectQ.pop_front();
      checkOutput({e.tag, ".stall"},    bus.stall,      e.stall);
      checkOutput({e.tag, ".cmp_mode"}, bus.cmp_mode,   e.mode);
      checkOutput({e.tag, ".fwd_rs"},   bus.fwd_rs_sel, e.rsSel);
      checkOutput({e.tag, ".fwd_rt"},   bus.fwd_rt_sel, e.rtSel);
      checkOutput({e.tag, ".br_taken"}, bus.br_taken,   e.taken);
    end
  endtask

  // One full cycle: drive after the falling edge, sample before the rising edge
  task automatic runCycle(
    input string tag, input logic valid, input logic isBr, input logic useRt,
    input logic [4:0] rs, input logic [4:0] rt, input logic [3:0] mode,
    input logic wrEn, input logic [4:0] wrReg, input logic [1:0] tnew,
    input logic cmpRes, input logic expStall, input logic [3:0] expMode,
    input logic [1:0] expRs, input logic [1:0] expRt, input logic expTaken);
    applyStimulus(tag, valid, isBr, useRt, rs, rt, mode, wrEn, wrReg, tnew,
                  cmpRes, expStall, expMode, expRs, expRt, expTaken);
    #1;
    compareOutputs();
    @(posedge clk);
    @(negedge clk);
  endtask

`ifdef BRANCH_PERF_EN
  task automatic checkPerfZero(input string tag);
    checkOutput({tag, ".perf_branches"},  perfBranches, 32'd0);
    checkOutput({tag, ".perf_taken"},     perfTaken,    32'd0);
    checkOutput({tag, ".perf_stall_cyc"}, perfStallCyc, 32'd0);
  endtask
`endif

  // Keeps a broken design from hanging the run
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached, got timeout, expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    reset = 1'b1;
    applyStimulus("init", 0, 0, 0, 0, 0, CMP_NONE, 0, 0, 0, 0, 0, CMP_NONE, 0, 0, 0);
    void'(expectQ.pop_front());
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;

    // Reset state
    runCycle("reset_idle", 0, 0, 0, 0, 0, CMP_NONE, 0, 0, 0, 0, 0, CMP_NONE, FWD_RF, FWD_RF, 0);

    // 1: beq $1,$2 with nothing in flight resolves immediately
    runCycle("t1_beq", 1, 1, 1, 5'd1, 5'd2, CMP_BEQ, 0, 0, 0, 1, 0, CMP_BEQ, FWD_RF, FWD_RF, 1);

    // 2: lw $3 (tnew 2) then beq $3,$0: two stall cycles, then WB forward
    runCycle("t2_lw",     1, 0, 0, 5'd29, 5'd3, CMP_NONE, 1, 5'd3, 2'd2, 0, 0, CMP_NONE, FWD_RF, FWD_RF, 0);
    runCycle("t2_stall1", 1, 1, 1, 5'd3,  5'd0, CMP_BEQ,  0, 0, 0, 1, 1, CMP_NONE, FWD_RF, FWD_RF, 0);
    runCycle("t2_stall2", 1, 1, 1, 5'd3,  5'd0, CMP_BEQ,  0, 0, 0, 1, 1, CMP_NONE, FWD_RF, FWD_RF, 0);
    runCycle("t2_resolve",1, 1, 1, 5'd3,  5'd0, CMP_BEQ,  0, 0, 0, 1, 0, CMP_BEQ,  FWD_WB, FWD_RF, 1);

    // 3: addu $4 (tnew 1) then bne $4,$4: one stall, both operands from MEM
    runCycle("t3_addu",   1, 0, 0, 5'd6, 5'd7, CMP_NONE, 1, 5'd4, 2'd1, 0, 0, CMP_NONE, FWD_RF, FWD_RF, 0);
    runCycle("t3_stall",  1, 1, 1, 5'd4, 5'd4, CMP_BNE,  0, 0, 0, 0, 1, CMP_NONE, FWD_RF, FWD_RF, 0);
    runCycle("t3_resolve",1, 1, 1, 5'd4, 5'd4, CMP_BNE,  0, 0, 0, 0, 0, CMP_BNE,  FWD_MEM, FWD_MEM, 0);

    // 4: addu $5 (tnew 0) twice then bgtz $5: no stall, EX beats MEM
    runCycle("t4_addu1", 1, 0, 0, 5'd8, 5'd9, CMP_NONE, 1, 5'd5, 2'd0, 0, 0, CMP_NONE, FWD_RF, FWD_RF, 0);
    runCycle("t4_addu2", 1, 0, 0, 5'd5, 5'd9, CMP_NONE, 1, 5'd5, 2'd0, 0, 0, CMP_NONE, FWD_EX, FWD_RF, 0);
    runCycle("t4_bgtz",  1, 1, 0, 5'd5, 5'd0, CMP_BGTZ, 0, 0, 0, 1, 0, CMP_BGTZ, FWD_EX, FWD_RF, 1);

    // 5: write to $0 is not tracked, beq $0,$0 resolves from the register file
    runCycle("t5_wr0", 1, 0, 0, 5'd10, 5'd11, CMP_NONE, 1, 5'd0, 2'd2, 0, 0, CMP_NONE, FWD_RF, FWD_RF, 0);
    runCycle("t5_beq", 1, 1, 1, 5'd0,  5'd0,  CMP_BEQ,  0, 0, 0, 1, 0, CMP_BEQ,  FWD_RF, FWD_RF, 1);

    // 6: reset during a stall abandons the branch and empties the tracker
    runCycle("t6_lw",     1, 0, 0, 5'd29, 5'd3, CMP_NONE, 1, 5'd3, 2'd2, 0, 0, CMP_NONE, FWD_RF, FWD_RF, 0);
    runCycle("t6_stall1", 1, 1, 1, 5'd3,  5'd0, CMP_BEQ,  0, 0, 0, 1, 1, CMP_NONE, FWD_RF, FWD_RF, 0);
    reset = 1'b1;
    runCycle("t6_rststall", 1, 1, 1, 5'd3, 5'd0, CMP_BEQ, 0, 0, 0, 1, 1, CMP_NONE, FWD_RF, FWD_RF, 0);
    reset = 1'b0;
`ifdef BRANCH_PERF_EN
    checkPerfZero("t6_perf");
`endif
    runCycle("t6_after", 1, 1, 1, 5'd3, 5'd0, CMP_BEQ, 0, 0, 0, 1, 0, CMP_BEQ, FWD_RF, FWD_RF, 1);

    // 7: an in-flight rt producer is ignored when the branch only uses rs
    runCycle("t7_addu", 1, 0, 0, 5'd0, 5'd0, CMP_NONE, 1, 5'd7, 2'd1, 0, 0, CMP_NONE, FWD_RF, FWD_RF, 0);
    runCycle("t7_bgez", 1, 1, 0, 5'd6, 5'd7, CMP_BGEZ, 0, 0, 0, 0, 0, CMP_BGEZ, FWD_RF, FWD_RF, 0);

    // 8: longest latency (tnew 3) gives three stall cycles
    runCycle("t8_mul",     1, 0, 0, 5'd7, 5'd0, CMP_NONE, 1, 5'd9, 2'd3, 0, 0, CMP_NONE, FWD_MEM, FWD_RF, 0);
    runCycle("t8_stall1",  1, 1, 1, 5'd9, 5'd9, CMP_BEQ,  0, 0, 0, 1, 1, CMP_NONE, FWD_RF, FWD_RF, 0);
    runCycle("t8_stall2",  1, 1, 1, 5'd9, 5'd9, CMP_BEQ,  0, 0, 0, 1, 1, CMP_NONE, FWD_RF, FWD_RF, 0);
    runCycle("t8_stall3",  1, 1, 1, 5'd9, 5'd9, CMP_BEQ,  0, 0, 0, 1, 1, CMP_NONE, FWD_RF, FWD_RF, 0);
    runCycle("t8_resolve", 1, 1, 1, 5'd9, 5'd9, CMP_BEQ,  0, 0, 0, 1, 0, CMP_BEQ,  FWD_RF, FWD_RF, 1);

    // Idle slot after the branch
    runCycle("final_idle", 0, 0, 0, 0, 0, CMP_NONE, 0, 0, 0, 1, 0, CMP_NONE, FWD_RF, FWD_RF, 0);

    checkOutput("queue_drain", expectQ.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", checkCount, failCount);
    $finish;
  end

endmodule
